// File: rtl/dispense_pkg.sv
// Shared types and constants for the dispenser command transmitter.
// Holds the FSM state encoding and the command field widths.
package dispense_pkg;

  localparam int STATE_W = 3;
  localparam int AMT_W   = 2;

  localparam logic [STATE_W-1:0] IDLE_CODE = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ASSERT,
    RELEASE,
    BACKOFF
  } fsm_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous acknowledge from the dispenser.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dispense_cmd_tx.sv
// Sends one state/amount command to the dispenser controller using a
// candyflag/signalrecieved four-phase handshake with timeout and retry.
module dispense_cmd_tx
  import dispense_pkg::*;
#(
  parameter int SETUP_CYC   = 4,
  parameter int TIMEOUT_CYC = 12000,
  parameter int MAX_RETRY   = 3
) (
  input  logic               clk_x1,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic [STATE_W-1:0] cmd_state,
  input  logic [AMT_W-1:0]   cmd_amount,
  output logic               cmd_ready,
  output logic [STATE_W-1:0] teststate,
  output logic [AMT_W-1:0]   stateamount,
  output logic               candyflag,
  input  logic               signalrecieved,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // SETUP is checked one cycle later than BACKOFF because the acceptance
  // edge itself is the first cycle of SETUP-hold time.
  localparam logic [CNT_W-1:0] SETUP_LIM   = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] BACKOFF_LIM = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LIM      = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(TIMEOUT_CYC);
  localparam logic [RTY_W-1:0] RTY_MAX     = RTY_W'(MAX_RETRY);

  fsm_t             state;
  logic [CNT_W-1:0] cnt;
  logic [RTY_W-1:0] retry;
  logic             ack_s;
  logic             retry_ok;

  sync_2ff u_ack_sync (
    .clk (clk_x1),
    .rst (rst),
    .d   (signalrecieved),
    .q   (ack_s)
  );

  assign retry_ok = (retry < RTY_MAX);

  always_ff @(posedge clk_x1) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      retry       <= '0;
      teststate   <= '0;
      stateamount <= '0;
      candyflag   <= 1'b0;
      busy        <= 1'b0;
      cmd_ready   <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (cmd_valid) begin
            if (cmd_state == IDLE_CODE) begin
              err <= 1'b1;
            end else begin
              teststate   <= cmd_state;
              stateamount <= cmd_amount;
              retry       <= '0;
              busy        <= 1'b1;
              cmd_ready   <= 1'b0;
              state       <= SETUP;
            end
          end
        end

        SETUP: begin
          if (cnt >= SETUP_LIM && !ack_s) begin
            candyflag <= 1'b1;
            cnt       <= '0;
            state     <= ASSERT;
          end else if (cnt >= TO_LIM) begin
            cnt <= '0;
            if (retry_ok) begin
              retry <= retry + 1'b1;
              state <= BACKOFF;
            end else begin
              err         <= 1'b1;
              busy        <= 1'b0;
              cmd_ready   <= 1'b1;
              teststate   <= '0;
              stateamount <= '0;
              state       <= IDLE;
            end
          end
        end

        ASSERT: begin
          if (ack_s) begin
            candyflag <= 1'b0;
            cnt       <= '0;
            state     <= RELEASE;
          end else if (cnt >= TO_LIM) begin
            candyflag <= 1'b0;
            cnt       <= '0;
            if (retry_ok) begin
              retry <= retry + 1'b1;
              state <= BACKOFF;
            end else begin
              err         <= 1'b1;
              busy        <= 1'b0;
              cmd_ready   <= 1'b1;
              teststate   <= '0;
              stateamount <= '0;
              state       <= IDLE;
            end
          end
        end

        RELEASE: begin
          // release wins over a timeout landing on the same edge
          if (!ack_s || cnt >= TO_LIM) begin
            done        <= !ack_s;
            err         <= ack_s;
            cnt         <= '0;
            busy        <= 1'b0;
            cmd_ready   <= 1'b1;
            teststate   <= '0;
            stateamount <= '0;
            state       <= IDLE;
          end
        end

        BACKOFF: begin
          if (cnt >= BACKOFF_LIM) begin
            candyflag <= 1'b1;
            cnt       <= '0;
            state     <= ASSERT;
          end
        end

        default: begin
          candyflag   <= 1'b0;
          cnt         <= '0;
          busy        <= 1'b0;
          cmd_ready   <= 1'b1;
          teststate   <= '0;
          stateamount <= '0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
